// File: rtl/pcs_gen_pkg.sv
// Shared constants, frame type and block helpers for the 257b
// BASE-R stimulus generator.
package pcs_gen_pkg;

    localparam int DATA_WIDTH           = 64;
    localparam int HDR_WIDTH            = 2;
    localparam int FRAME_WIDTH          = DATA_WIDTH + HDR_WIDTH;
    localparam int CONTROL_WIDTH        = 8;
    localparam int TRANSCODER_BLOCKS    = 4;
    localparam int TRANSCODER_WIDTH     = 257;
    localparam int TRANSCODER_HDR_WIDTH = 4;

    localparam logic [HDR_WIDTH-1:0] SYNC_DATA = 2'b01;
    localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] TYPE_CTRL  = 8'h1E;
    localparam logic [6:0] CHAR_IDLE  = 7'h00;
    localparam logic [6:0] CHAR_ERROR = 7'h1E;
    localparam logic [7:0] MII_IDLE   = 8'h07;

    localparam logic [DATA_WIDTH-1:0] DATA_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

    // x^64+x^63+x^61+x^60+1 as tap mask on bits 63,62,60,59
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
    localparam logic [63:0] LFSR_SEED = 64'hACE1_ACE1_ACE1_ACE1;

    localparam int SCR_WIDTH = 58;
    localparam int SCR_TAP_A = 38;
    localparam int SCR_TAP_B = 57;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] payload;
        logic [HDR_WIDTH-1:0]  sync;
    } frame_t;

    function automatic frame_t data_frame(input logic [DATA_WIDTH-1:0] d);
        frame_t f;
        f.payload = d;
        f.sync    = SYNC_DATA;
        return f;
    endfunction

    function automatic frame_t ctrl_frame(input logic [6:0] ch);
        frame_t f;
        f.payload = {{8{ch}}, TYPE_CTRL};
        f.sync    = SYNC_CTRL;
        return f;
    endfunction

    function automatic frame_t encode_block(
        input logic [DATA_WIDTH-1:0]    txd,
        input logic [CONTROL_WIDTH-1:0] txc
    );
        frame_t f;
        if (txc == '0)
            f = data_frame(txd);
        else if (txc == '1 && txd == {8{MII_IDLE}})
            f = ctrl_frame(CHAR_IDLE);
        else
            f = ctrl_frame(CHAR_ERROR);
        return f;
    endfunction

    // First control block keeps only the upper nibble of its type byte
    function automatic logic [DATA_WIDTH-5:0] strip_type(input frame_t f);
        return {f.payload[DATA_WIDTH-1:8], f.payload[7:4]};
    endfunction

    function automatic logic [TRANSCODER_WIDTH-1:0] transcode(
        input frame_t [TRANSCODER_BLOCKS-1:0] blk
    );
        logic [TRANSCODER_HDR_WIDTH-1:0] d;
        logic [TRANSCODER_WIDTH-1:0]     r;
        for (int i = 0; i < TRANSCODER_BLOCKS; i++)
            d[i] = (blk[i].sync == SYNC_DATA);
        r = '0;
        priority case (1'b1)
            (&d):  r = {blk[3].payload, blk[2].payload,
                        blk[1].payload, blk[0].payload, 1'b1};
            !d[0]: r = {blk[3].payload, blk[2].payload,
                        blk[1].payload, strip_type(blk[0]), d, 1'b0};
            !d[1]: r = {blk[3].payload, blk[2].payload,
                        strip_type(blk[1]), blk[0].payload, d, 1'b0};
            !d[2]: r = {blk[3].payload, strip_type(blk[2]),
                        blk[1].payload, blk[0].payload, d, 1'b0};
            !d[3]: r = {strip_type(blk[3]), blk[2].payload,
                        blk[1].payload, blk[0].payload, d, 1'b0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pcs_257b_scrambler.sv
// Self-synchronous x^58+x^39+1 scrambler over bits 1..256 of a
// 257b block; bit 0 (the header) is sent in the clear.
module pcs_257b_scrambler
    import pcs_gen_pkg::*;
(
    input  logic                        clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    input  logic                        i_bypass,
    input  logic [TRANSCODER_WIDTH-1:0] i_data,
    output logic [TRANSCODER_WIDTH-1:0] o_data
);

    logic [SCR_WIDTH-1:0]        state_q;
    logic [SCR_WIDTH-1:0]        state_d;
    logic [TRANSCODER_WIDTH-1:0] scr_d;

    always_comb begin
        state_d = state_q;
        scr_d   = i_data;
        for (int i = 1; i < TRANSCODER_WIDTH; i++) begin
            scr_d[i] = i_data[i] ^ state_d[SCR_TAP_A] ^ state_d[SCR_TAP_B];
            state_d  = {state_d[SCR_WIDTH-2:0], scr_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= '1;
            o_data  <= '0;
        end else if (i_valid) begin
            if (i_bypass) begin
                o_data <= i_data;
            end else begin
                o_data  <= scr_d;
                state_q <= state_d;
            end
        end
    end

endmodule

// File: rtl/pcs_257b_frame_generator.sv
// Eight-frame 66b stimulus source with clause-91 style 257b
// transcoding and scrambling of two four-block streams.
module pcs_257b_frame_generator
    import pcs_gen_pkg::*;
#(
    parameter int PROB = 30
) (
    input  logic                         clk,
    input  logic                         i_rst,
    input  logic [DATA_WIDTH-1:0]        i_txd,
    input  logic [CONTROL_WIDTH-1:0]     i_txc,
    input  logic [TRANSCODER_BLOCKS-1:0] i_data_sel_0,
    input  logic [TRANSCODER_BLOCKS-1:0] i_data_sel_1,
    input  logic [2:0]                   i_valid,
    input  logic                         i_enable,
    input  logic                         i_random_0,
    input  logic                         i_random_1,
    input  logic                         i_tx_test_mode,
    output logic [FRAME_WIDTH-1:0]       o_frame_0,
    output logic [FRAME_WIDTH-1:0]       o_frame_1,
    output logic [FRAME_WIDTH-1:0]       o_frame_2,
    output logic [FRAME_WIDTH-1:0]       o_frame_3,
    output logic [FRAME_WIDTH-1:0]       o_frame_4,
    output logic [FRAME_WIDTH-1:0]       o_frame_5,
    output logic [FRAME_WIDTH-1:0]       o_frame_6,
    output logic [FRAME_WIDTH-1:0]       o_frame_7,
    output logic [TRANSCODER_WIDTH-1:0]  o_tx_coded_f0,
    output logic [TRANSCODER_WIDTH-1:0]  o_tx_coded_f1,
    output logic [TRANSCODER_WIDTH-1:0]  o_tx_scrambled_f0,
    output logic [TRANSCODER_WIDTH-1:0]  o_tx_scrambled_f1
);

    localparam logic [8:0] CTRL_THRESH = 9'((PROB * 256) / 100);

    logic [63:0]  lfsr_q;
    frame_t [7:0] frame_q;
    frame_t [7:0] pat_frame;
    frame_t [6:0] stage_q;
    frame_t       mii_blk;
    logic [2:0]   cnt_q;
    logic [2:0]   cnt_eff;
    logic         enable_q;
    logic         mode_switch;
    logic [7:0]   data_sel;
    logic [7:0]   rnd_en;
    logic [7:0]   is_data;

    assign data_sel = {i_data_sel_1, i_data_sel_0};
    assign rnd_en   = {{4{i_random_1}}, {4{i_random_0}}};

    always_comb begin
        mode_switch = (i_enable != enable_q);
        cnt_eff     = mode_switch ? 3'd0 : cnt_q;
        mii_blk     = encode_block(i_txd, i_txc);
        for (int j = 0; j < 8; j++) begin
            is_data[j]   = rnd_en[j]
                         ? ({1'b0, lfsr_q[8*j +: 8]} >= CTRL_THRESH)
                         : data_sel[j];
            pat_frame[j] = is_data[j] ? data_frame(DATA_PATTERN)
                                      : ctrl_frame(CHAR_IDLE);
        end
    end

    // Slot 7 is never stored: the eighth block loads straight into frame 7
    always_ff @(posedge clk) begin
        if (i_rst) begin
            lfsr_q   <= LFSR_SEED;
            frame_q  <= '0;
            stage_q  <= '0;
            cnt_q    <= '0;
            enable_q <= 1'b0;
        end else begin
            enable_q <= i_enable;
            if (i_valid[0]) begin
                lfsr_q <= {lfsr_q[62:0], ^(lfsr_q & LFSR_TAPS)};
                if (i_enable) begin
                    frame_q <= pat_frame;
                end else if (cnt_eff == 3'd7) begin
                    frame_q <= {mii_blk, stage_q};
                end else begin
                    stage_q[cnt_eff] <= mii_blk;
                end
            end
            if (i_valid[0] && !i_enable)
                cnt_q <= cnt_eff + 3'd1;
            else if (mode_switch)
                cnt_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_tx_coded_f0 <= '0;
            o_tx_coded_f1 <= '0;
        end else if (i_valid[1]) begin
            o_tx_coded_f0 <= transcode(frame_q[3:0]);
            o_tx_coded_f1 <= transcode(frame_q[7:4]);
        end
    end

    pcs_257b_scrambler u_scr_f0 (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid[2]),
        .i_bypass (i_tx_test_mode),
        .i_data   (o_tx_coded_f0),
        .o_data   (o_tx_scrambled_f0)
    );

    pcs_257b_scrambler u_scr_f1 (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid[2]),
        .i_bypass (i_tx_test_mode),
        .i_data   (o_tx_coded_f1),
        .o_data   (o_tx_scrambled_f1)
    );

    assign o_frame_0 = frame_q[0];
    assign o_frame_1 = frame_q[1];
    assign o_frame_2 = frame_q[2];
    assign o_frame_3 = frame_q[3];
    assign o_frame_4 = frame_q[4];
    assign o_frame_5 = frame_q[5];
    assign o_frame_6 = frame_q[6];
    assign o_frame_7 = frame_q[7];

endmodule

// File: tb/tb_pcs_257b_frame_generator.sv
// Scoreboard bench for the 257b frame generator: a reference model
// queues expected frames/coded/scrambled words each driven cycle.
module tb_pcs_257b_frame_generator;

    localparam logic [63:0] PAT  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] SEED = 64'hACE1_ACE1_ACE1_ACE1;
    localparam int          THR  = (30 * 256) / 100;

    logic         clk = 1'b0;
    logic         i_rst;
    logic [63:0]  i_txd;
    logic [7:0]   i_txc;
    logic [3:0]   i_data_sel_0, i_data_sel_1;
    logic [2:0]   i_valid;
    logic         i_enable, i_random_0, i_random_1, i_tx_test_mode;
    logic [65:0]  o_frame_0, o_frame_1, o_frame_2, o_frame_3;
    logic [65:0]  o_frame_4, o_frame_5, o_frame_6, o_frame_7;
    logic [256:0] o_tx_coded_f0, o_tx_coded_f1;
    logic [256:0] o_tx_scrambled_f0, o_tx_scrambled_f1;

    always #5 clk = ~clk;

    pcs_257b_frame_generator dut (
        .clk               (clk),
        .i_rst             (i_rst),
        .i_txd             (i_txd),
        .i_txc             (i_txc),
        .i_data_sel_0      (i_data_sel_0),
        .i_data_sel_1      (i_data_sel_1),
        .i_valid           (i_valid),
        .i_enable          (i_enable),
        .i_random_0        (i_random_0),
        .i_random_1        (i_random_1),
        .i_tx_test_mode    (i_tx_test_mode),
        .o_frame_0         (o_frame_0),
        .o_frame_1         (o_frame_1),
        .o_frame_2         (o_frame_2),
        .o_frame_3         (o_frame_3),
        .o_frame_4         (o_frame_4),
        .o_frame_5         (o_frame_5),
        .o_frame_6         (o_frame_6),
        .o_frame_7         (o_frame_7),
        .o_tx_coded_f0     (o_tx_coded_f0),
        .o_tx_coded_f1     (o_tx_coded_f1),
        .o_tx_scrambled_f0 (o_tx_scrambled_f0),
        .o_tx_scrambled_f1 (o_tx_scrambled_f1)
    );

    typedef struct {
        logic [527:0] frm;
        logic [513:0] cod;
        logic [513:0] scr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    logic [63:0]  m_lfsr;
    logic [527:0] m_frm;
    logic [65:0]  m_stage [8];
    int           m_cnt;
    logic         m_en_q;
    logic [256:0] m_cod0, m_cod1, m_scr0, m_scr1;
    logic [57:0]  m_st0, m_st1;

    task automatic chk(input string tag, input logic [527:0] obs,
                       input logic [527:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] b_data(input logic [63:0] d);
        return {d, 2'b01};
    endfunction

    function automatic logic [65:0] b_ctrl(input logic [6:0] c);
        return {{8{c}}, 8'h1E, 2'b10};
    endfunction

    function automatic logic [65:0] b_encode(input logic [63:0] d,
                                             input logic [7:0] c);
        if (c == 8'h00) return b_data(d);
        if (c == 8'hFF && d == 64'h0707_0707_0707_0707) return b_ctrl(7'h00);
        return b_ctrl(7'h1E);
    endfunction

    // Serial packing: header, flags, then payload bits block by block
    function automatic logic [256:0] b_transcode(input logic [263:0] blks);
        logic [256:0] r;
        logic [3:0]   fl;
        int           pos;
        bit           seen;
        r = '0;
        for (int i = 0; i < 4; i++) fl[i] = (blks[66*i +: 2] == 2'b01);
        if (fl == 4'hF) begin
            r[0] = 1'b1;
            for (int i = 0; i < 4; i++) r[1 + 64*i +: 64] = blks[66*i + 2 +: 64];
            return r;
        end
        r[4:1] = fl;
        pos = 5;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 64; b++) begin
                if (!fl[i] && !seen && b < 4) continue;
                r[pos] = blks[66*i + 2 + b];
                pos++;
            end
            if (!fl[i]) seen = 1;
        end
        return r;
    endfunction

    task automatic b_scramble(input logic [256:0] din, inout logic [57:0] st,
                              output logic [256:0] dout);
        dout[0] = din[0];
        for (int i = 1; i < 257; i++) begin
            dout[i] = din[i] ^ st[38] ^ st[57];
            st = {st[56:0], dout[i]};
        end
    endtask

    task automatic model_update();
        logic       sw, rnd, sel, ctl;
        logic [7:0] r;
        if (i_rst) begin
            m_lfsr = SEED;
            m_frm  = '0;
            m_cnt  = 0;
            m_en_q = 1'b0;
            m_cod0 = '0; m_cod1 = '0;
            m_scr0 = '0; m_scr1 = '0;
            m_st0  = '1; m_st1  = '1;
            return;
        end
        if (i_valid[2]) begin
            if (i_tx_test_mode) begin
                m_scr0 = m_cod0;
                m_scr1 = m_cod1;
            end else begin
                b_scramble(m_cod0, m_st0, m_scr0);
                b_scramble(m_cod1, m_st1, m_scr1);
            end
        end
        if (i_valid[1]) begin
            m_cod0 = b_transcode(m_frm[263:0]);
            m_cod1 = b_transcode(m_frm[527:264]);
        end
        sw = (i_enable != m_en_q);
        m_en_q = i_enable;
        if (sw) m_cnt = 0;
        if (i_valid[0]) begin
            if (i_enable) begin
                for (int j = 0; j < 8; j++) begin
                    r   = m_lfsr[8*j +: 8];
                    rnd = (j < 4) ? i_random_0 : i_random_1;
                    sel = (j < 4) ? i_data_sel_0[j] : i_data_sel_1[j-4];
                    ctl = rnd ? (int'(r) < THR) : !sel;
                    m_frm[66*j +: 66] = ctl ? b_ctrl(7'h00) : b_data(PAT);
                end
            end else begin
                m_stage[m_cnt] = b_encode(i_txd, i_txc);
                if (m_cnt == 7)
                    for (int j = 0; j < 8; j++) m_frm[66*j +: 66] = m_stage[j];
                m_cnt = (m_cnt + 1) % 8;
            end
            m_lfsr = {m_lfsr[62:0], m_lfsr[63] ^ m_lfsr[62] ^ m_lfsr[60] ^ m_lfsr[59]};
        end
    endtask

    task automatic step();
        exp_t e;
        model_update();
        e.frm = m_frm;
        e.cod = {m_cod1, m_cod0};
        e.scr = {m_scr1, m_scr0};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("frames", {o_frame_7, o_frame_6, o_frame_5, o_frame_4,
                       o_frame_3, o_frame_2, o_frame_1, o_frame_0}, e.frm);
        chk("coded", {o_tx_coded_f1, o_tx_coded_f0}, e.cod);
        chk("scrambled", {o_tx_scrambled_f1, o_tx_scrambled_f0}, e.scr);
    endtask

    function automatic int ctl_count();
        int n;
        n = 0;
        n += (o_frame_0[1:0] == 2'b10); n += (o_frame_1[1:0] == 2'b10);
        n += (o_frame_2[1:0] == 2'b10); n += (o_frame_3[1:0] == 2'b10);
        n += (o_frame_4[1:0] == 2'b10); n += (o_frame_5[1:0] == 2'b10);
        n += (o_frame_6[1:0] == 2'b10); n += (o_frame_7[1:0] == 2'b10);
        return n;
    endfunction

    logic [63:0] mii_seq [8];
    logic [7:0]  txc_pick [4];
    int          n_ctl, n_tot;
    logic        in_win;

    initial begin
        mii_seq = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h3333_3333_3333_3333,
                    64'h5555_5555_5555_5555, 64'hDDDD_DDDD_DDDD_DDDD,
                    64'h7777_7777_7777_7777, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h0000_0000_0000_0000, 64'h1111_1111_1111_1111};
        txc_pick = '{8'h00, 8'hFF, 8'h0F, 8'h80};

        i_rst = 1'b1; i_txd = '0; i_txc = '0;
        i_data_sel_0 = '0; i_data_sel_1 = '0; i_valid = '0;
        i_enable = 1'b1; i_random_0 = 1'b0; i_random_1 = 1'b0;
        i_tx_test_mode = 1'b0;
        step();
        step();
        chk("reset_frame0", o_frame_0, '0);
        chk("reset_scr_f1", o_tx_scrambled_f1, '0);

        i_rst = 1'b0; i_valid = 3'b111;
        i_data_sel_0 = 4'b1111; i_data_sel_1 = 4'b0000;
        repeat (3) step();
        chk("pat_data_frame0", o_frame_0, {PAT, 2'b01});
        chk("pat_data_frame3", o_frame_3, {PAT, 2'b01});
        chk("pat_idle_frame4", o_frame_4, {56'h0, 8'h1E, 2'b10});
        chk("pat_all_data_cod", o_tx_coded_f0, {PAT, PAT, PAT, PAT, 1'b1});

        i_data_sel_0 = 4'b0000;
        repeat (2) step();
        chk("ctl_hdr", o_tx_coded_f0[4:0], 5'b00000);
        chk("ctl_blk0", o_tx_coded_f0[64:5], {56'h0, 4'h1});
        chk("ctl_blk1", o_tx_coded_f0[128:65], 64'h1E);
        chk("ctl_blk3", o_tx_coded_f0[256:193], 64'h1E);

        i_data_sel_0 = 4'b1110;
        repeat (2) step();
        chk("mix_hdr", o_tx_coded_f0[4:0], 5'b11100);
        chk("mix_blk0", o_tx_coded_f0[64:5], {56'h0, 4'h1});
        chk("mix_blk1", o_tx_coded_f0[128:65], PAT);
        chk("mix_blk3", o_tx_coded_f0[256:193], PAT);

        i_enable = 1'b0;
        for (int k = 0; k < 8; k++) begin
            i_txd = mii_seq[k];
            step();
        end
        chk("mii_frame0", o_frame_0, {mii_seq[0], 2'b01});
        chk("mii_frame3", o_frame_3, {mii_seq[3], 2'b01});
        chk("mii_frame7", o_frame_7, {mii_seq[7], 2'b01});
        i_txd = '0;
        step();
        chk("mii_cod_f0", o_tx_coded_f0,
            {mii_seq[3], mii_seq[2], mii_seq[1], mii_seq[0], 1'b1});

        // Slots: idle, error (partial txc), data, error (FF non-idle), idle x4
        for (int k = 0; k < 7; k++) step();
        for (int k = 0; k < 8; k++) begin
            case (k)
                1:       begin i_txc = 8'h0F; i_txd = 64'h0707_0707_0707_0707; end
                2:       begin i_txc = 8'h00; i_txd = 64'h1234_5678_9ABC_DEF0; end
                3:       begin i_txc = 8'hFF; i_txd = PAT; end
                default: begin i_txc = 8'hFF; i_txd = 64'h0707_0707_0707_0707; end
            endcase
            step();
        end
        chk("mii_idle", o_frame_0, {56'h0, 8'h1E, 2'b10});
        chk("mii_err_txc", o_frame_1, {{8{7'h1E}}, 8'h1E, 2'b10});
        chk("mii_err_ff", o_frame_3, {{8{7'h1E}}, 8'h1E, 2'b10});

        // Mode switches mid-fill and stage enables toggling
        for (int k = 0; k < 80; k++) begin
            i_valid      = 3'($urandom_range(0, 7));
            if (k % 9 == 0) i_enable = ~i_enable;
            i_txc        = txc_pick[$urandom_range(0, 3)];
            i_txd        = {$urandom, $urandom};
            i_data_sel_0 = 4'($urandom);
            i_data_sel_1 = 4'($urandom);
            i_random_0   = 1'($urandom);
            i_random_1   = 1'($urandom);
            i_tx_test_mode = ($urandom_range(0, 4) == 0);
            step();
        end

        i_valid = 3'b111; i_enable = 1'b1;
        i_tx_test_mode = 1'b1;
        repeat (6) step();
        i_tx_test_mode = 1'b0;
        repeat (6) step();

        i_rst = 1'b1;
        step();
        chk("midrst_frame5", o_frame_5, '0);
        chk("midrst_cod_f0", o_tx_coded_f0, '0);
        chk("midrst_scr_f0", o_tx_scrambled_f0, '0);
        i_rst = 1'b0;

        i_random_0 = 1'b1; i_random_1 = 1'b1;
        n_ctl = 0; n_tot = 0;
        step();
        for (int k = 0; k < 10000; k++) begin
            i_data_sel_0 = 4'($urandom);
            i_data_sel_1 = 4'($urandom);
            step();
            n_ctl += ctl_count();
            n_tot += 8;
        end
        in_win = (n_ctl * 100 >= 28 * n_tot) && (n_ctl * 100 <= 32 * n_tot);
        $display("random control frames %0d of %0d", n_ctl, n_tot);
        chk("rand_ctl_fraction", in_win, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcs_257b_frame_generator.md
Name: pcs_257b_frame_generator

Overview:
- Verification-side stimulus source for 64b/66b / 257b-transcoded BASE-R paths.
- Each cycle it produces eight 66b frames, either from fixed data/idle patterns or by encoding MII input (i_txd/i_txc).
- Frames 0-3 are transcoded into 257b stream f0 and frames 4-7 into stream f1, per the IEEE 802.3 clause 91 style.
- Each 257b stream is then scrambled with x^58+x^39+1.
- The output feeds the 257b checkers.

Parameters:
DATA_WIDTH, 64, payload bits per 66b block
HDR_WIDTH, 2, sync header bits
FRAME_WIDTH, DATA_WIDTH+HDR_WIDTH (66), frame width
CONTROL_WIDTH, 8, MII control bits (one per byte)
TRANSCODER_BLOCKS, 4, 66b blocks per 257b block
TRANSCODER_WIDTH, 257, transcoded block width
TRANSCODER_HDR_WIDTH, 4, per-block data/control flag field
PROB, 30, percentage of control frames in random mode (0-100)

Ports:
clk  in  1  clock, all logic on rising edge
i_rst  in  1  reset; one clock, synchronous, active-high
i_txd  in  64  MII data; byte 0 = bits [7:0]
i_txc  in  8  MII control; bit k qualifies byte k
i_data_sel_0  in  4  pattern mode: bit i=1 makes frame i data, 0 makes it control
i_data_sel_1  in  4  same for frames 4+i
i_valid  in  3  stage enables: [0] frame stage, [1] transcoder, [2] scrambler
i_enable  in  1  1 = pattern mode, 0 = MII encode mode
i_random_0  in  1  random data/control selection for frames 0-3
i_random_1  in  1  random data/control selection for frames 4-7
i_tx_test_mode  in  1  1 = scrambler bypass
o_frame_0..o_frame_7  out  66 each  generated frames
o_tx_coded_f0, o_tx_coded_f1  out  257 each  transcoded blocks
o_tx_scrambled_f0, o_tx_scrambled_f1  out  257 each  scrambled blocks

Behaviour:
Frame format:
- frame[1:0] is the sync header: 2'b01 = data, 2'b10 = control.
- frame[65:2] is the payload.
- Data pattern payload is 64'hAAAA_AAAA_AAAA_AAAA.
- Control (idle) payload is type 8'h1E in payload[7:0], followed by eight 7'h00 characters.

Pattern mode (i_enable=1):
- Frame i type comes from i_data_sel bit, or from the random draw when i_random_x=1; random overrides i_data_sel.
- Random source: 64-bit Fibonacci LFSR x^64+x^63+x^61+x^60+1, seed 64'hACE1_ACE1_ACE1_ACE1, advanced once per cycle while i_valid[0]=1.
- Frame j (0..7) uses LFSR bits [8j+7:8j] = r; the frame is control iff r < (PROB*256)/100, which is 76 for PROB=30.
- Frames register every cycle while i_valid[0]=1.

MII mode (i_enable=0):
- Each cycle the input is encoded into one block:
  - i_txc=8'h00 gives a data block with payload i_txd.
  - i_txc=8'hFF with all bytes 8'h07 gives an idle control block.
  - Anything else gives an error control block: type 8'h1E with eight 7'h1E characters.
- Blocks fill an 8-entry staging buffer with a 3-bit counter: first block goes to slot 0, the eighth to slot 7.
- When the counter wraps, all eight o_frame outputs load simultaneously.
- The counter advances only while i_valid[0]=1.
- Switching i_enable resets the counter to 0.

Transcoder, per stream (blocks p0..p3 = frames 0-3 or 4-7), registered while i_valid[1]=1:
- All four blocks data: bit0=1 and [256:1] = {p3,p2,p1,p0} payloads.
- Otherwise:
  - bit0=0.
  - [4:1] = flags, where bit 1+i = 1 if block i is data.
  - [256:5] = blocks in order 0..3, 64 bits each, except the first control block, whose type byte is reduced to its upper nibble ({p[63:8], p[7:4]}, 60 bits).

Scrambler, per stream, registered while i_valid[2]=1:
- Bit 0 passes unscrambled.
- Bits 1..256 are scrambled LSB-first, out = in ^ s[38] ^ s[57], with state shifting in the output bit.
- 58-bit state resets to all ones and persists across blocks.
- i_tx_test_mode=1: o_tx_scrambled = o_tx_coded and the state holds.

Latency (pattern mode, all valids high):
- Inputs to frames: 1 cycle.
- Frames to coded: +1 cycle.
- Coded to scrambled: +1 cycle.

Reset:
- All outputs go to 0; LFSR to its seed; scrambler state to all ones; counter to 0.
- Reset mid-operation discards staged blocks.
- A stage whose i_valid bit is low holds its registers.

Decomposition:
- Package pcs_gen_pkg: sync header constants, 8'h1E type, 7'h00/7'h1E characters, data pattern, LFSR polynomial and seed, a frame typedef, and an encode_block function.
- One sub-module, pcs_257b_scrambler, instantiated twice.

Test Plan:
- i_enable=1, i_data_sel_0=4'b1111 -> o_frame_0..3 = {64'hAAAA_AAAA_AAAA_AAAA,2'b01}; o_tx_coded_f0 = {4 x AAAA..,1'b1} two cycles after.
- i_data_sel_0=4'b0000 -> frames {56'h0,8'h1E,2'b10}; coded bit0=0, [4:1]=0, [64:5]={56'h0,4'h1}, remaining blocks {56'h0,8'h1E}.
- i_data_sel_0=4'b1110 -> flags 4'b1110; block 0 carries the reduced nibble 4'h1; blocks 1-3 are full AAAA payloads.
- i_random_0=1, PROB=30, 10000 frames -> control fraction 30% ±2%; i_data_sel ignored.
- i_enable=0, i_txc=0, i_txd = AAAA.., 3333.., 5555.., DDDD.., 7777.., FFFF.., 0000.., 1111.. -> after the 8th cycle, frames 0..7 hold those payloads with sync 01; coded_f0 = {DDDD..,5555..,3333..,AAAA..,1'b1}.
- i_tx_test_mode=1 -> scrambled equals coded every cycle; toggling back resumes the sequence from the held state; i_rst mid-run -> all outputs 0 next cycle.
